// File: rtl/crc8_0x31_checker.sv
// Receive-side CRC-8 (poly 0x31, init 0xFF) checker: strips the trailing CRC byte, forwards payload,
// reports per-frame status and saturating good/bad counters. One byte of holding, one output register.
module crc8_0x31_checker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  input  logic             s_last,
  output logic             s_ready,
  output logic             m_valid,
  output logic [7:0]       m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             frame_done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             runt,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t     state, state_nxt;
  logic [7:0] crc_q, crc_nxt;
  logic [7:0] hold_data, hold_nxt;
  logic [7:0] fin;
  logic       accept;
  logic       out_load;
  logic       done_nxt, ok_nxt, err_nxt, runt_nxt;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] t;
    logic [7:0] n;
    t    = c ^ d;
    n[0] = t[0] ^ t[3] ^ t[4] ^ t[6];
    n[1] = t[1] ^ t[4] ^ t[5] ^ t[7];
    n[2] = t[2] ^ t[5] ^ t[6];
    n[3] = t[3] ^ t[6] ^ t[7];
    n[4] = t[0] ^ t[3] ^ t[6] ^ t[7];
    n[5] = t[0] ^ t[1] ^ t[3] ^ t[6] ^ t[7];
    n[6] = t[1] ^ t[2] ^ t[4] ^ t[7];
    n[7] = t[2] ^ t[3] ^ t[5];
    return n;
  endfunction

  // The output register frees up in the same cycle it is drained, so ready follows m_ready directly.
  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready && !clr;
  assign fin     = crc8_step(crc_q, hold_data);

  always_comb begin
    state_nxt = state;
    crc_nxt   = crc_q;
    hold_nxt  = hold_data;
    out_load  = 1'b0;
    done_nxt  = 1'b0;
    ok_nxt    = 1'b0;
    err_nxt   = 1'b0;
    runt_nxt  = 1'b0;
    if (clr) begin
      state_nxt = EMPTY;
      crc_nxt   = 8'hFF;
    end else if (accept) begin
      case (state)
        EMPTY: begin
          if (s_last) begin
            done_nxt = 1'b1;
            runt_nxt = 1'b1;
            err_nxt  = 1'b1;
          end else begin
            hold_nxt  = s_data;
            state_nxt = HOLD;
          end
        end
        HOLD: begin
          out_load = 1'b1;
          if (s_last) begin
            // The held byte is the last payload byte; the incoming byte is the CRC to compare.
            done_nxt  = 1'b1;
            ok_nxt    = (fin == s_data);
            err_nxt   = (fin != s_data);
            crc_nxt   = 8'hFF;
            state_nxt = EMPTY;
          end else begin
            crc_nxt  = fin;
            hold_nxt = s_data;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      crc_q     <= 8'hFF;
      hold_data <= 8'h00;
    end else begin
      state     <= state_nxt;
      crc_q     <= crc_nxt;
      hold_data <= hold_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      m_last  <= 1'b0;
    end else if (clr) begin
      m_valid <= 1'b0;
    end else if (out_load) begin
      m_valid <= 1'b1;
      m_data  <= hold_data;
      m_last  <= s_last;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_done <= 1'b0;
      crc_ok     <= 1'b0;
      crc_err    <= 1'b0;
      runt       <= 1'b0;
    end else begin
      frame_done <= done_nxt;
      crc_ok     <= ok_nxt;
      crc_err    <= err_nxt;
      runt       <= runt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else if (clr) begin
      ok_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (ok_nxt && (ok_cnt != '1))
        ok_cnt <= ok_cnt + CNT_ONE;
      if (err_nxt && (err_cnt != '1))
        err_cnt <= err_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_crc8_0x31_checker.sv
// Randomized and directed bench for crc8_0x31_checker against a frame-level bitwise CRC model.
module tb_crc8_0x31_checker;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             clr = 1'b0;
  logic             s_valid = 1'b0;
  logic [7:0]       s_data = 8'h00;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic             m_valid;
  logic [7:0]       m_data;
  logic             m_last;
  logic             m_ready = 1'b0;
  logic             frame_done, crc_ok, crc_err, runt;
  logic [CNT_W-1:0] ok_cnt, err_cnt;

  crc8_0x31_checker #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .frame_done(frame_done), .crc_ok(crc_ok), .crc_err(crc_err), .runt(runt),
    .ok_cnt(ok_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic l; } bt_t;

  bt_t        in_q[$];
  bt_t        exp_out[$];
  logic [7:0] frame[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         vprob = 100, rprob = 100;
  int         stall_cnt = 0;
  bit         stall_on_first = 0;
  bit         clr_req = 0;
  logic       exp_fd = 0, exp_ok = 0, exp_err = 0, exp_runt = 0;
  int         m_ok = 0, m_err = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data;
  logic       prev_last;
  int         fd_seen = 0, ok_seen = 0, err_seen = 0, runt_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // MSB-first shift-register CRC, the textbook form of poly 0x31.
  function automatic logic [7:0] crc_bits(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int b = 0; b < 8; b++)
      r = r[7] ? ((r << 1) ^ 8'h31) : (r << 1);
    return r;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  task automatic model_reset();
    frame.delete();
    exp_out.delete();
    m_ok = 0; m_err = 0;
    exp_fd = 0; exp_ok = 0; exp_err = 0; exp_runt = 0;
    prev_stall = 0;
  endtask

  task automatic cycle();
    bit in_hs, out_hs;
    bt_t b, o;
    logic [7:0] fin;
    @(negedge clk);
    chk("frame_done", frame_done, exp_fd);
    chk("crc_ok", crc_ok, exp_ok);
    chk("crc_err", crc_err, exp_err);
    chk("runt", runt, exp_runt);
    chk("ok_cnt", ok_cnt, m_ok);
    chk("err_cnt", err_cnt, m_err);
    if (frame_done) begin
      fd_seen++;
      if (crc_ok) ok_seen++;
      if (crc_err) err_seen++;
      if (runt) runt_seen++;
    end
    if (prev_stall) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_data);
      chk("stall_last", m_last, prev_last);
    end
    if (stall_on_first && m_valid) begin
      stall_on_first = 0;
      stall_cnt = 5;
    end
    s_valid = (in_q.size() > 0) && ($urandom_range(99) < vprob);
    if (s_valid) begin
      s_data = in_q[0].d;
      s_last = in_q[0].l;
    end else begin
      s_data = 8'($urandom);
      s_last = 1'($urandom);
    end
    if (stall_cnt > 0) begin
      m_ready = 1'b0;
      stall_cnt--;
    end else begin
      m_ready = ($urandom_range(99) < rprob);
    end
    clr = clr_req;
    clr_req = 0;
    #1;
    in_hs  = s_valid && s_ready;
    out_hs = m_valid && m_ready;
    if (m_valid && !m_ready) chk("s_ready_bp", s_ready, 0);
    prev_stall = m_valid && !m_ready && !clr;
    prev_data  = m_data;
    prev_last  = m_last;
    exp_fd = 0; exp_ok = 0; exp_err = 0; exp_runt = 0;
    if (in_hs) b = in_q.pop_front();
    if (clr) begin
      frame.delete();
      exp_out.delete();
      m_ok = 0; m_err = 0;
    end else begin
      if (out_hs) begin
        if (exp_out.size() == 0) begin
          chk("spurious_out", m_data, 0);
          chk("spurious_out_cnt", exp_out.size(), 1);
        end else begin
          o = exp_out.pop_front();
          chk("m_data", m_data, o.d);
          chk("m_last", m_last, o.l);
        end
      end
      if (in_hs) begin
        // A payload byte is only known to be last once the next byte (CRC) shows up.
        if (frame.size() > 0) exp_out.push_back('{d: frame[$], l: b.l});
        if (b.l) begin
          exp_fd = 1;
          if (frame.size() == 0) begin
            exp_runt = 1; exp_err = 1;
            m_err = sat_inc(m_err);
          end else begin
            fin = 8'hFF;
            foreach (frame[i]) fin = crc_bits(fin, frame[i]);
            exp_ok  = (fin == b.d);
            exp_err = !exp_ok;
            if (exp_ok) m_ok = sat_inc(m_ok);
            else        m_err = sat_inc(m_err);
          end
          frame.delete();
        end else begin
          frame.push_back(b.d);
        end
      end
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    s_valid = 0; clr = 0;
    #2 rst = 1'b1;
    #1;
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_data"}, m_data, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_crc_ok"}, crc_ok, 0);
    chk({tag, "_crc_err"}, crc_err, 0);
    chk({tag, "_runt"}, runt, 0);
    chk({tag, "_ok_cnt"}, ok_cnt, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    model_reset();
    in_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1 chk({tag, "_s_ready"}, s_ready, 1);
  endtask

  task automatic drain(input string tag, input int maxc);
    int n = 0;
    while ((in_q.size() > 0 || exp_out.size() > 0 || m_valid) && n < maxc) begin
      cycle();
      n++;
    end
    cycle();
    cycle();
    chk({tag, "_drained"}, (n < maxc), 1);
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int len);
    if (len == 3) begin
      in_q.push_back('{d: b0, l: 1'b0});
      in_q.push_back('{d: b1, l: 1'b0});
      in_q.push_back('{d: b2, l: 1'b1});
    end else if (len == 2) begin
      in_q.push_back('{d: b0, l: 1'b0});
      in_q.push_back('{d: b1, l: 1'b1});
    end else begin
      in_q.push_back('{d: b0, l: 1'b1});
    end
  endtask

  initial begin
    int f0, o0, e0, r0;
    do_reset("rst0");

    // Plan 1 and 2: good then bad 2-byte frame
    push_frame(8'h00, 8'hAC, 8'h00, 2);
    drain("t1", 50);
    chk("t1_ok_cnt", ok_cnt, 1);
    chk("t1_ok_seen", ok_seen, 1);
    push_frame(8'h00, 8'hAD, 8'h00, 2);
    drain("t2", 50);
    chk("t2_err_cnt", err_cnt, 1);
    chk("t2_ok_cnt", ok_cnt, 1);
    chk("t2_err_seen", err_seen, 1);

    // Plan 3: runt
    do_reset("rst3");
    push_frame(8'h55, 8'h00, 8'h00, 1);
    drain("t3", 50);
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_runt_seen", runt_seen, 1);

    // Plan 4: 5-cycle stall after first output
    do_reset("rst4");
    stall_on_first = 1;
    push_frame(8'h00, 8'h00, 8'h81, 3);
    drain("t4", 60);
    chk("t4_ok_cnt", ok_cnt, 1);

    // Plan 5: back-to-back frames
    do_reset("rst5");
    f0 = fd_seen; o0 = ok_seen; e0 = err_seen;
    push_frame(8'h00, 8'hAC, 8'h00, 2);
    push_frame(8'h00, 8'hAD, 8'h00, 2);
    drain("t5", 50);
    chk("t5_fd_pulses", fd_seen - f0, 2);
    chk("t5_ok", ok_seen - o0, 1);
    chk("t5_err", err_seen - e0, 1);

    // Plan 6a: clr abort mid-frame
    f0 = fd_seen;
    in_q.push_back('{d: 8'h12, l: 1'b0});
    in_q.push_back('{d: 8'h34, l: 1'b0});
    for (int i = 0; i < 20 && in_q.size() > 0; i++) cycle();
    clr_req = 1;
    cycle();
    cycle();
    chk("t6_clr_no_status", fd_seen - f0, 0);
    chk("t6_clr_ok_zero", ok_cnt, 0);
    push_frame(8'h00, 8'hAC, 8'h00, 2);
    drain("t6a", 50);
    chk("t6a_ok_cnt", ok_cnt, 1);

    // Plan 6b: async reset mid-frame
    in_q.push_back('{d: 8'h12, l: 1'b0});
    in_q.push_back('{d: 8'h34, l: 1'b0});
    for (int i = 0; i < 20 && in_q.size() > 0; i++) cycle();
    f0 = fd_seen;
    do_reset("t6b_rst");
    push_frame(8'h00, 8'hAC, 8'h00, 2);
    drain("t6b", 50);
    chk("t6b_ok_cnt", ok_cnt, 1);
    chk("t6b_one_status", fd_seen - f0, 1);

    // Random frames with gaps, backpressure and corrupted CRCs; long enough to saturate 4-bit counters
    vprob = 70;
    rprob = 60;
    r0 = runt_seen;
    for (int f = 0; f < 60; f++) begin
      int len;
      logic [7:0] c, d;
      len = $urandom_range(6);
      c = 8'hFF;
      for (int i = 0; i < len; i++) begin
        d = 8'($urandom);
        c = crc_bits(c, d);
        in_q.push_back('{d: d, l: 1'b0});
      end
      if ($urandom_range(99) < 30) c = c ^ 8'($urandom_range(255, 1));
      in_q.push_back('{d: c, l: 1'b1});
    end
    drain("rand", 20000);
    chk("rand_ok_sat", ok_cnt, (m_ok >= 15) ? 15 : m_ok);
    chk("rand_runts_seen", (runt_seen > r0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
